// File: rtl/avst_pkg.sv
// Shared types and helpers for the Avalon-ST packet FIFO.
// Sink FSM states, drop counter width and Empty field sizing.
package avst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    DISCARD
  } avst_fifo_state_e;

  localparam int DROP_CNT_WIDTH = 16;

  function automatic int empty_width(input int dw, input int sw);
    return (dw / sw > 1) ? $clog2(dw / sw) : 1;
  endfunction

endpackage

// File: rtl/avst_pkt_fifo_ram.sv
// Simple dual-port beat storage for the packet FIFO.
// Synchronous write port, asynchronous read port.
module avst_pkt_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 38,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/avst_pkt_fifo.sv
// Avalon-ST packet FIFO: cut-through or store-and-forward with
// packet sanitation, show-ahead output register and drop counter.
module avst_pkt_fifo
  import avst_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SYMBOL_WIDTH = 8,
  parameter int DEPTH        = 16,
  parameter int STORE_FWD    = 0,
  parameter int DROP_ERR     = 1,
  localparam int EW = empty_width(DATA_WIDTH, SYMBOL_WIDTH),
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RBI,
  input  logic [DATA_WIDTH-1:0]     SnkData_DI,
  input  logic                      SnkValid_SI,
  output logic                      SnkReady_SO,
  input  logic                      SnkSop_SI,
  input  logic                      SnkEop_SI,
  input  logic [EW-1:0]             SnkEmpty_SI,
  input  logic                      SnkError_SI,
  output logic [DATA_WIDTH-1:0]     SrcData_DO,
  output logic                      SrcValid_SO,
  input  logic                      SrcReady_SI,
  output logic                      SrcSop_SO,
  output logic                      SrcEop_SO,
  output logic [EW-1:0]             SrcEmpty_SO,
  output logic                      SrcError_SO,
  output logic [PW-1:0]             FillLevel_DO,
  output logic [DROP_CNT_WIDTH-1:0] DropCnt_DO,
  output logic                      Overflow_SO
);

  localparam int AW = PW - 1;
  localparam int BW = DATA_WIDTH + EW + 3;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  avst_fifo_state_e state_q, state_d;
  logic rdy_en_q;
  logic [BW-1:0] out_q, out_d;
  logic vld_q, vld_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic ovf_q, ovf_d;

  logic [PW-1:0] fill, base;
  logic [AW-1:0] waddr;
  logic [BW-1:0] beat_w, beat_r;
  logic [1:0] drop_inc;
  logic [DROP_CNT_WIDTH:0] drop_sum;
  logic full, acc, we, restart, load;

  assign fill        = wr_ptr_q - rd_ptr_q;
  assign full        = (fill == PW'(DEPTH));
  assign SnkReady_SO = rdy_en_q & (!full | (state_q == DISCARD));
  assign acc         = SnkValid_SI & SnkReady_SO;
  assign beat_w      = {SnkData_DI, SnkEmpty_SI, SnkSop_SI,
                        SnkEop_SI, SnkError_SI};
  assign restart     = (state_q == IN_PKT) & SnkSop_SI;

  avst_pkt_fifo_ram #(
    .DEPTH(DEPTH),
    .WIDTH(BW)
  ) u_ram (
    .clk  (Clk_CI),
    .we   (we),
    .waddr(waddr),
    .wdata(beat_w),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(beat_r)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    state_d  = state_q;
    we       = 1'b0;
    base     = SnkSop_SI ? cm_ptr_q : wr_ptr_q;
    waddr    = wr_ptr_q[AW-1:0];
    drop_inc = 2'd0;
    ovf_d    = 1'b0;
    if (STORE_FWD == 0) begin
      if (acc) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      cm_ptr_d = wr_ptr_d;
    end else begin
      unique case (state_q)
        DISCARD: begin
          if (acc && SnkEop_SI) state_d = IDLE;
        end
        default: begin
          // RAM holds nothing but the open packet: it can never complete
          if (state_q == IN_PKT && full && cm_ptr_q == rd_ptr_q) begin
            wr_ptr_d = cm_ptr_q;
            ovf_d    = 1'b1;
            drop_inc = 2'd1;
            state_d  = DISCARD;
          end else if (acc) begin
            if (state_q == IDLE && !SnkSop_SI) begin
              drop_inc = 2'd1;
            end else if (SnkEop_SI && SnkError_SI && DROP_ERR != 0) begin
              wr_ptr_d = cm_ptr_q;
              drop_inc = {1'b0, restart} + 2'd1;
              state_d  = IDLE;
            end else begin
              we       = 1'b1;
              waddr    = base[AW-1:0];
              wr_ptr_d = base + PW'(1);
              drop_inc = {1'b0, restart};
              if (SnkEop_SI) begin
                cm_ptr_d = base + PW'(1);
                state_d  = IDLE;
              end else begin
                state_d  = IN_PKT;
              end
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + {{(DROP_CNT_WIDTH-1){1'b0}}, drop_inc};
    drop_d   = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
  end

  always_comb begin
    load     = (cm_ptr_q != rd_ptr_q) && (!vld_q || SrcReady_SI);
    rd_ptr_d = rd_ptr_q;
    out_d    = out_q;
    vld_d    = vld_q;
    if (load) begin
      out_d    = beat_r;
      vld_d    = 1'b1;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (SrcReady_SI) begin
      vld_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      rdy_en_q <= 1'b0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      out_q    <= out_d;
      vld_q    <= vld_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  assign {SrcData_DO, SrcEmpty_SO, SrcSop_SO,
          SrcEop_SO, SrcError_SO} = out_q;
  assign SrcValid_SO  = vld_q;
  assign FillLevel_DO = fill;
  assign DropCnt_DO   = drop_q;
  assign Overflow_SO  = ovf_q;

endmodule

// File: tb/tb_avst_pkt_fifo.sv
// Bench for avst_pkt_fifo: a cut-through and a store-and-forward
// instance checked against a packet-level queue model.
module tb_avst_pkt_fifo;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  emp;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  typedef struct {
    beat_t b;
    int    cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_data [2];
  logic [1:0]  s_emp [2];
  logic [1:0]  s_valid, s_sop, s_eop, s_err, o_ready;
  wire  [1:0]  s_ready, o_valid, o_sop, o_eop, o_err, ovf;
  wire  [31:0] o_data [2];
  wire  [1:0]  o_emp [2];
  wire  [4:0]  fill [2];
  wire  [15:0] dcnt [2];

  avst_pkt_fifo #(
    .DATA_WIDTH(32), .SYMBOL_WIDTH(8), .DEPTH(DEPTH),
    .STORE_FWD(0), .DROP_ERR(1)
  ) u_ct (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .SnkData_DI(s_data[0]), .SnkValid_SI(s_valid[0]),
    .SnkReady_SO(s_ready[0]), .SnkSop_SI(s_sop[0]),
    .SnkEop_SI(s_eop[0]), .SnkEmpty_SI(s_emp[0]),
    .SnkError_SI(s_err[0]),
    .SrcData_DO(o_data[0]), .SrcValid_SO(o_valid[0]),
    .SrcReady_SI(o_ready[0]), .SrcSop_SO(o_sop[0]),
    .SrcEop_SO(o_eop[0]), .SrcEmpty_SO(o_emp[0]),
    .SrcError_SO(o_err[0]),
    .FillLevel_DO(fill[0]), .DropCnt_DO(dcnt[0]),
    .Overflow_SO(ovf[0])
  );

  avst_pkt_fifo #(
    .DATA_WIDTH(32), .SYMBOL_WIDTH(8), .DEPTH(DEPTH),
    .STORE_FWD(1), .DROP_ERR(1)
  ) u_sf (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .SnkData_DI(s_data[1]), .SnkValid_SI(s_valid[1]),
    .SnkReady_SO(s_ready[1]), .SnkSop_SI(s_sop[1]),
    .SnkEop_SI(s_eop[1]), .SnkEmpty_SI(s_emp[1]),
    .SnkError_SI(s_err[1]),
    .SrcData_DO(o_data[1]), .SrcValid_SO(o_valid[1]),
    .SrcReady_SI(o_ready[1]), .SrcSop_SO(o_sop[1]),
    .SrcEop_SO(o_eop[1]), .SrcEmpty_SO(o_emp[1]),
    .SrcError_SO(o_err[1]),
    .FillLevel_DO(fill[1]), .DropCnt_DO(dcnt[1]),
    .Overflow_SO(ovf[1])
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  beat_t exp0[$], exp1[$], pk[$];
  obs_t  obs0[$], obs1[$];
  bit    inp, disc;
  int    mdrop[2], movf, novf[2], stall[2], eop_cyc[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endfunction

  function automatic beat_t mk(logic [31:0] d, logic [1:0] emp,
                               logic sop, logic eop, logic err);
    beat_t b;
    b.d = d; b.emp = emp; b.sop = sop; b.eop = eop; b.err = err;
    return b;
  endfunction

  function automatic void clear_model();
    exp0.delete(); exp1.delete(); pk.delete();
    obs0.delete(); obs1.delete();
    inp = 0; disc = 0; movf = 0;
    for (int m = 0; m < 2; m++) begin
      mdrop[m] = 0; novf[m] = 0; stall[m] = 0; eop_cyc[m] = 0;
    end
  endfunction

  // Packet-level view: a packet is released whole, or not at all.
  function automatic void model_acc(int m, beat_t b);
    if (b.eop) eop_cyc[m] = cyc;
    if (m == 0) begin
      exp0.push_back(b);
      return;
    end
    if (disc) begin
      if (b.eop) disc = 0;
      return;
    end
    if (b.sop) begin
      if (inp) mdrop[1]++;
      pk.delete();
      inp = 1;
    end else if (!inp) begin
      mdrop[1]++;
      return;
    end
    if (b.eop && b.err) begin
      mdrop[1]++;
      pk.delete();
      inp = 0;
      return;
    end
    pk.push_back(b);
    if (b.eop) begin
      foreach (pk[i]) exp1.push_back(pk[i]);
      pk.delete();
      inp = 0;
    end else if (pk.size() == DEPTH) begin
      mdrop[1]++;
      movf++;
      pk.delete();
      inp = 0;
      disc = 1;
    end
  endfunction

  task automatic mon(input int m);
    beat_t got, e;
    obs_t  o;
    int    qs;
    if (!chk_en) return;
    if (o_valid[m] && o_ready[m]) begin
      got = {o_data[m], o_emp[m], o_sop[m], o_eop[m], o_err[m]};
      o.b = got;
      o.cyc = cyc;
      qs = (m == 0) ? exp0.size() : exp1.size();
      if (m == 0) obs0.push_back(o);
      else obs1.push_back(o);
      if (qs == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out%0d: got beat %h required none", m, got);
      end else begin
        if (m == 0) e = exp0.pop_front();
        else e = exp1.pop_front();
        chk(m == 0 ? "out_ct" : "out_sf", got, e);
      end
    end
    chk(m == 0 ? "rdy_ct" : "rdy_sf", s_ready[m], fill[m] != 5'd16);
    if (s_valid[m] && s_ready[m])
      model_acc(m, {s_data[m], s_emp[m], s_sop[m], s_eop[m], s_err[m]});
    if (s_valid[m] && !s_ready[m]) stall[m]++;
    if (ovf[m]) novf[m]++;
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  task automatic do_reset();
    chk_en = 1'b0;
    #1;
    rst_n = 1'b0;
    s_valid = '0;
    clear_model();
    #2;
    for (int m = 0; m < 2; m++) begin
      chk("rst_valid", o_valid[m], 1'b0);
      chk("rst_ready", s_ready[m], 1'b0);
      chk("rst_fill", fill[m], 5'd0);
      chk("rst_drop", dcnt[m], 16'd0);
      chk("rst_ovf", ovf[m], 1'b0);
      chk("rst_data", o_data[m], 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) chk("rdy_after_rst", s_ready[m], 1'b1);
    chk_en = 1'b1;
  endtask

  task automatic send(input int m, input beat_t b);
    int t;
    t = 0;
    s_data[m] = b.d; s_emp[m] = b.emp;
    s_sop[m] = b.sop; s_eop[m] = b.eop; s_err[m] = b.err;
    s_valid[m] = 1'b1;
    @(negedge clk);
    while (!s_ready[m]) begin
      t++;
      if (t > 2000) begin
        n_chk++;
        n_fail++;
        $display("FAIL send%0d timeout: ready %0b required 1", m, s_ready[m]);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_valid[m] = 1'b0;
  endtask

  task automatic send_pkt(input int m, input int n, input logic [31:0] d0,
                          input logic [1:0] emp, input logic err);
    for (int i = 0; i < n; i++)
      send(m, mk(d0 + 32'(i), (i == n - 1) ? emp : 2'd0,
                 i == 0, i == n - 1, (i == n - 1) ? err : 1'b0));
  endtask

  task automatic drain(input int m);
    int t;
    t = 0;
    while (((m == 0) ? exp0.size() : exp1.size()) != 0 || o_valid[m]) begin
      @(posedge clk);
      t++;
      if (t > 3000) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain%0d timeout: %0d beats left required 0", m,
                 (m == 0) ? exp0.size() : exp1.size());
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m);
    int n;
    logic err;
    for (int p = 0; p < 1000; p++) begin
      n = $urandom_range(1, 16);
      err = (m == 0) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
      send_pkt(m, n, $urandom, 2'($urandom), err);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit done0, done1;

  initial begin
    s_valid = '0; s_sop = '0; s_eop = '0; s_err = '0; o_ready = '0;
    for (int m = 0; m < 2; m++) begin
      s_data[m] = '0;
      s_emp[m] = '0;
    end

    // 1: cut-through 4-beat packet
    do_reset();
    o_ready = 2'b11;
    send_pkt(0, 4, 32'hA000_0000, 2'd2, 1'b0);
    drain(0);
    chk("t1_cnt", obs0.size(), 4);
    if (obs0.size() == 4) begin
      chk("t1_sop0", obs0[0].b.sop, 1'b1);
      chk("t1_d0", obs0[0].b.d, 32'hA000_0000);
      chk("t1_sop1", obs0[1].b.sop, 1'b0);
      chk("t1_eop3", obs0[3].b.eop, 1'b1);
      chk("t1_emp3", obs0[3].b.emp, 2'd2);
      chk("t1_d3", obs0[3].b.d, 32'hA000_0003);
    end

    // 2: store-and-forward holds output until Eop is accepted
    send_pkt(1, 3, 32'hB000_0000, 2'd1, 1'b0);
    drain(1);
    chk("t2_cnt", obs1.size(), 3);
    if (obs1.size() == 3) begin
      chk("t2_after_eop", obs1[0].cyc > eop_cyc[1], 1'b1);
      chk("t2_consec", obs1[2].cyc - obs1[0].cyc, 2);
      chk("t2_d0", obs1[0].b.d, 32'hB000_0000);
      chk("t2_emp2", obs1[2].b.emp, 2'd1);
    end

    // 3: errored packet dropped, next one intact
    do_reset();
    o_ready = 2'b11;
    send_pkt(1, 3, 32'hC000_0000, 2'd1, 1'b1);
    chk("t3_fill", fill[1], 5'd0);
    chk("t3_drop", dcnt[1], 16'd1);
    send_pkt(1, 2, 32'hD000_0000, 2'd3, 1'b0);
    drain(1);
    chk("t3_cnt", obs1.size(), 2);
    if (obs1.size() == 2) chk("t3_d0", obs1[0].b.d, 32'hD000_0000);
    chk("t3_model_drop", mdrop[1], 1);

    // 4: oversized packet discarded
    do_reset();
    o_ready = 2'b11;
    send_pkt(1, 20, 32'hE000_0000, 2'd0, 1'b0);
    send_pkt(1, 2, 32'hF000_0000, 2'd1, 1'b0);
    drain(1);
    chk("t4_ovf", novf[1], 1);
    chk("t4_model_ovf", movf, 1);
    chk("t4_drop", dcnt[1], 16'd1);
    chk("t4_stall", stall[1], 1);
    chk("t4_cnt", obs1.size(), 2);
    if (obs1.size() == 2) chk("t4_d0", obs1[0].b.d, 32'hF000_0000);

    // 5: random traffic through both modes
    do_reset();
    done0 = 0;
    done1 = 0;
    fork
      begin drv(0); done0 = 1; end
      begin drv(1); done1 = 1; end
      begin
        while (!(done0 && done1)) begin
          @(posedge clk);
          #1;
          o_ready = 2'($urandom);
        end
      end
    join
    o_ready = 2'b11;
    drain(0);
    drain(1);
    chk("t5_drop_ct", dcnt[0], 16'd0);
    chk("t5_drop_sf", dcnt[1], 16'(mdrop[1]));

    // 6: restart Sop, orphan beat, then reset mid-packet
    do_reset();
    o_ready = 2'b11;
    send(1, mk(32'd1, 2'd0, 1'b1, 1'b0, 1'b0));
    send(1, mk(32'd2, 2'd0, 1'b0, 1'b0, 1'b0));
    send(1, mk(32'd3, 2'd0, 1'b1, 1'b0, 1'b0));
    send(1, mk(32'd4, 2'd0, 1'b0, 1'b0, 1'b0));
    send(1, mk(32'd5, 2'd1, 1'b0, 1'b1, 1'b0));
    send(1, mk(32'd6, 2'd0, 1'b0, 1'b0, 1'b0));
    drain(1);
    chk("t6_drop", dcnt[1], 16'd2);
    chk("t6_cnt", obs1.size(), 3);
    if (obs1.size() == 3) begin
      chk("t6_d0", obs1[0].b.d, 32'd3);
      chk("t6_d2", obs1[2].b.d, 32'd5);
    end
    o_ready = 2'b00;
    send_pkt(1, 2, 32'h77, 2'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_pre_valid", o_valid[1], 1'b1);
    send(1, mk(32'h99, 2'd0, 1'b1, 1'b0, 1'b0));
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_valid[1], 1'b0);
    chk("t6_rst_fill", fill[1], 5'd0);
    chk("t6_rst_drop", dcnt[1], 16'd0);
    do_reset();
    o_ready = 2'b11;
    send_pkt(1, 2, 32'h5500, 2'd0, 1'b0);
    drain(1);
    chk("t6_post_cnt", obs1.size(), 2);
    if (obs1.size() == 2) chk("t6_post_d0", obs1[0].b.d, 32'h5500);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
